sram_stream_ctrl: RTL and testbench
===================================

Name: sram_stream_ctrl

Overview:
- Initiator-side controller for the single-port 2048x128 feature SRAM macro used by the k-furthest-neighbors datapath.
- Turns a valid/ready write stream and burst-read commands into CEN/WEN/A/D accesses.
- Returns read data as a backpressured valid/ready stream.
- Sits between the feature loader/distance engine and each SRAM instance, one controller per instance.

Parameters:
ADDR_W, 11, SRAM address width (depth 2^ADDR_W)
DATA_W, 128, SRAM word width
LEN_W, 12, burst length field width (must equal ADDR_W+1)

Ports:
CLK  in  1  clock, all logic on posedge
reset  in  1  synchronous active-high reset
wr_valid  in  1  write request valid
wr_ready  out  1  write accepted when wr_valid&&wr_ready
wr_addr  in  ADDR_W  write address
wr_data  in  DATA_W  write data
rd_start  in  1  burst-read command (single-cycle qualifier)
rd_base  in  ADDR_W  burst start address
rd_len  in  LEN_W  burst length in words
rd_busy  out  1  burst in progress
out_valid  out  1  read data valid
out_ready  in  1  consumer ready
out_data  out  DATA_W  read word
out_last  out  1  marks final word of burst
done  out  1  one-cycle pulse after final word handshake
CEN  out  1  SRAM chip enable, active low
WEN  out  1  SRAM write enable, low=write, high=read
A  out  ADDR_W  SRAM address
D  out  DATA_W  SRAM write data
Q  in  DATA_W  SRAM read data, valid the cycle after the read edge, held until the next read

Behaviour:
- Reset: state IDLE, buffer flushed, out_valid=0, out_last=0, rd_busy=0, done=0, inflight=0. CEN=1, WEN=1, A=0, D=0 while reset is high and whenever no access is issued.
- States: IDLE, READ.
- IDLE, writes:
  - wr_ready = (state==IDLE) && !reset && !(rd_start && rd_len!=0).
  - On a write handshake, drive CEN=0, WEN=0, A=wr_addr, D=wr_data combinationally in the same cycle; the SRAM writes at that edge.
  - Write throughput is 1 word/cycle.
- IDLE, rd_start:
  - rd_start with rd_len!=0 latches base and length, sets rd_busy, and moves to READ.
  - Read has priority over a simultaneous wr_valid.
  - rd_len=0 is ignored: no access, no busy, no done.
  - rd_len>2^ADDR_W is clamped to 2^ADDR_W.
- READ, issue:
  - Issue a read (CEN=0, WEN=1, A=next address) when words remain and (occ + inflight - pop) < 2.
  - occ = buffer entries (0..2); inflight = read issued last cycle; pop = out_valid && out_ready.
  - When no issue, CEN=1 and A is held.
  - Address increments mod 2^ADDR_W; wraps 0x7FF->0x000 at the default ADDR_W.
- READ, capture:
  - In the cycle after an issue, Q is pushed into a 2-entry FIFO at the clock edge.
  - out_data/out_valid/out_last come from the FIFO head, registered.
  - Latency: rd_start sampled at edge E0, first read issued at E1, first out_valid high after E2.
  - With out_ready held high, one word per cycle, with no bubbles after the first.
- Backpressure:
  - When out_ready is low, at most 2 words are buffered plus none in flight. No word is dropped or duplicated.
  - Simultaneous push and pop in a full FIFO is legal; occupancy is unchanged.
- out_last is high exactly with the rd_len-th word.
- Completion:
  - On that word's handshake, the state returns to IDLE.
  - rd_busy falls and done pulses for one cycle, both in the cycle after the handshake edge.
  - Writes may be accepted from that cycle on.
- rd_start while READ is ignored. wr_ready=0 throughout READ.
- Reset mid-burst: at the reset edge, the burst is aborted, the FIFO is flushed, out_valid goes to 0, and no done is generated. A new burst after reset operates normally.

Test Plan:
- Write 0xA0..0xA3 to addresses 0..3, then rd_base=0, rd_len=4, out_ready=1 -> out_data A0,A1,A2,A3 on consecutive cycles starting 2 cycles after the start edge; out_last on A3; single done pulse; A driven 0,1,2,3.
- Wrap: write W0..W3 to 0x7FE,0x7FF,0x000,0x001; read base 0x7FE len 4 -> A sequence 7FE,7FF,000,001; data W0..W3 in order.
- Backpressure: len 8 with out_ready alternating 1,0, then held low 5 cycles mid-burst -> all 8 words exactly once and in order; at most 2 reads issued without a pop; CEN=1 during the stall.
- Priority/ignore cases:
  - rd_start and wr_valid in the same cycle -> wr_ready=0, burst starts, write accepted only after done.
  - rd_len=0 -> no CEN activity, no done.
  - rd_start during READ -> no effect.
- Reset asserted on the 3rd output word of a len-6 burst -> next cycle out_valid=0, rd_busy=0, no done; following burst base 0 len 2 returns the correct data.
- Full sweep: write data=address to all 2048 words, read base 0 len 2048 (and len 4095, which clamps to 2048) -> 2048 words matching address, out_last on word 0x7FF.

Source files
------------

// File: rtl/sram_stream_ctrl.sv
// Controller for one single-port feature SRAM: streams writes straight through
// and runs burst reads into a 2-entry skid FIFO with a backpressured output.
module sram_stream_ctrl #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 128,
  parameter int LEN_W  = 12
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_start,
  input  logic [ADDR_W-1:0] rd_base,
  input  logic [LEN_W-1:0]  rd_len,
  output logic              rd_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              done,
  output logic              CEN,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  input  logic [DATA_W-1:0] Q
);

  typedef enum logic {IDLE, READ} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(1) << ADDR_W;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_addr, r_a_hold;
  logic [LEN_W-1:0]  r_remain;
  logic              r_inflight, r_infl_last;
  logic [DATA_W-1:0] r_fifo_data [2];
  logic [1:0]        r_fifo_last;
  logic [1:0]        r_occ;
  logic              r_done;

  logic              w_rd_go, w_pop, w_push, w_issue, w_last_pop;
  logic [2:0]        w_level;
  logic [LEN_W-1:0]  w_len_clamp;

  assign out_valid  = (r_occ != 2'd0);
  assign out_data   = r_fifo_data[0];
  assign out_last   = out_valid && r_fifo_last[0];
  assign rd_busy    = (r_state == READ);
  assign done       = r_done;

  assign w_rd_go     = (r_state == IDLE) && !reset && rd_start && (rd_len != '0);
  assign w_len_clamp = (rd_len > MAX_LEN) ? MAX_LEN : rd_len;
  assign w_pop       = out_valid && out_ready;
  assign w_push      = r_inflight;
  assign w_last_pop  = w_pop && r_fifo_last[0];
  // Words that will sit in the FIFO after this edge; a new issue must still fit.
  assign w_level     = {1'b0, r_occ} + {2'b0, r_inflight} - {2'b0, w_pop};
  assign w_issue     = (r_state == READ) && !reset && (r_remain != '0) && (w_level < 3'd2);

  always_ff @(posedge CLK) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    wr_ready    = 1'b0;
    CEN         = 1'b1;
    WEN         = 1'b1;
    A           = '0;
    D           = '0;
    case (r_state)
      IDLE: begin
        wr_ready = !reset && !(rd_start && (rd_len != '0));
        if (w_rd_go) begin
          w_state_nxt = READ;
        end else if (wr_valid && wr_ready) begin
          CEN = 1'b0;
          WEN = 1'b0;
          A   = wr_addr;
          D   = wr_data;
        end
      end
      READ: begin
        A = r_a_hold;
        if (w_issue) begin
          CEN = 1'b0;
          A   = r_addr;
        end
        if (w_last_pop) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (reset) A = '0;
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_addr      <= '0;
      r_a_hold    <= '0;
      r_remain    <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
      r_occ       <= 2'd0;
      r_fifo_last <= 2'b00;
      r_done      <= 1'b0;
      for (int i = 0; i < 2; i++) r_fifo_data[i] <= '0;
    end else begin
      r_done      <= w_last_pop;
      r_inflight  <= w_issue;
      r_infl_last <= w_issue && (r_remain == LEN_W'(1));
      if (w_rd_go) begin
        r_addr   <= rd_base;
        r_remain <= w_len_clamp;
      end else if (w_issue) begin
        r_addr   <= r_addr + ADDR_W'(1);
        r_remain <= r_remain - LEN_W'(1);
        r_a_hold <= r_addr;
      end
      // Head lives in slot 0; Q is valid the cycle after the issue edge.
      case ({w_push, w_pop})
        2'b10: begin
          r_fifo_data[r_occ[0]] <= Q;
          r_fifo_last[r_occ[0]] <= r_infl_last;
          r_occ                 <= r_occ + 2'd1;
        end
        2'b01: begin
          r_fifo_data[0] <= r_fifo_data[1];
          r_fifo_last[0] <= r_fifo_last[1];
          r_occ          <= r_occ - 2'd1;
        end
        2'b11: begin
          if (r_occ == 2'd2) begin
            r_fifo_data[0] <= r_fifo_data[1];
            r_fifo_last[0] <= r_fifo_last[1];
            r_fifo_data[1] <= Q;
            r_fifo_last[1] <= r_infl_last;
          end else begin
            r_fifo_data[0] <= Q;
            r_fifo_last[0] <= r_infl_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stream_ctrl.sv
// Directed bench for sram_stream_ctrl with a behavioural single-port SRAM.
module tb_sram_stream_ctrl;

  logic         CLK = 1'b0;
  logic         reset = 1'b1;
  logic         wr_valid = 1'b0, wr_ready;
  logic [10:0]  wr_addr = '0;
  logic [127:0] wr_data = '0;
  logic         rd_start = 1'b0;
  logic [10:0]  rd_base = '0;
  logic [11:0]  rd_len = '0;
  logic         rd_busy, out_valid, out_last, done;
  logic         out_ready = 1'b0;
  logic [127:0] out_data;
  logic         CEN, WEN;
  logic [10:0]  A;
  logic [127:0] D;
  logic [127:0] Q = '0;

  logic [127:0] mem     [2048];
  logic [127:0] exp_mem [2048];
  int n_checks = 0;
  int n_err    = 0;

  sram_stream_ctrl dut (
    .CLK(CLK), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_start(rd_start), .rd_base(rd_base), .rd_len(rd_len), .rd_busy(rd_busy),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .done(done),
    .CEN(CEN), .WEN(WEN), .A(A), .D(D), .Q(Q)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (!CEN) begin
      if (!WEN) mem[A] <= D;
      else      Q      <= mem[A];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic wr(input logic [10:0] a, input logic [127:0] d);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    #1;
    chk("wr_ready", wr_ready, 1'b1);
    chk("wr_A", {CEN, WEN, A}, {2'b00, a});
    tick;
    wr_valid   = 1'b0;
    exp_mem[a] = d;
  endtask

  // mode 0: always ready; 1: alternating ready with a 5-cycle stall;
  // 2: always ready plus a stray rd_start mid-burst. Returns in the done cycle.
  task automatic burst(input logic [10:0] base, input logic [11:0] len,
                       input int mode, input string tag);
    int n, got, iss, dn, maxo;
    logic ok_a, ok_wr;
    logic [10:0] ea;
    n = (len > 12'd2048) ? 2048 : int'(len);
    got = 0; iss = 0; dn = 0; maxo = 0; ok_a = 1'b1; ok_wr = 1'b1;
    rd_start = 1'b1; rd_base = base; rd_len = len; out_ready = 1'b1;
    #1;
    chk({tag, "/start_wr_ready"}, wr_ready, 1'b0);
    chk({tag, "/start_CEN"}, CEN, 1'b1);
    tick;
    rd_start = 1'b0;
    for (int cyc = 0; cyc < 8 * n + 40 && got < n; cyc++) begin
      out_ready = (mode == 1) ? ((cyc % 2 == 0) && !(cyc >= 6 && cyc <= 10)) : 1'b1;
      rd_start  = (mode == 2) && (cyc == 2);
      if (mode == 2) begin rd_base = 11'h100; rd_len = 12'd5; end
      #1;
      if (wr_ready) ok_wr = 1'b0;
      if (!CEN) begin
        ea = base + 11'(iss);
        if (WEN !== 1'b1 || A !== ea) ok_a = 1'b0;
        iss++;
      end
      if (mode == 1 && cyc == 10) chk({tag, "/stall_CEN"}, CEN, 1'b1);
      if (out_valid && out_ready) begin
        ea = base + 11'(got);
        chk({tag, "/data"}, out_data, exp_mem[ea]);
        chk({tag, "/last"}, out_last, (got == n - 1));
        got++;
      end
      if (done) dn++;
      if (iss - got > maxo) maxo = iss - got;
      tick;
    end
    rd_start = 1'b0;
    chk({tag, "/words"}, got, n);
    chk({tag, "/issued"}, iss, n);
    chk({tag, "/addr_seq"}, ok_a, 1'b1);
    chk({tag, "/wr_blocked"}, ok_wr, 1'b1);
    chk({tag, "/outstanding<=2"}, (maxo <= 2), 1'b1);
    chk({tag, "/early_done"}, dn, 0);
    chk({tag, "/done"}, {done, rd_busy, out_valid, wr_ready}, 4'b1001);
  endtask

  initial begin
    logic ok;
    int got;
    for (int i = 0; i < 2048; i++) begin mem[i] = '0; exp_mem[i] = '0; end

    // reset state
    tick; tick;
    chk("rst_sram_if", {CEN, WEN, A, D}, {2'b11, 11'h0, 128'h0});
    chk("rst_status", {out_valid, out_last, rd_busy, done, wr_ready}, 5'b00000);
    reset = 1'b0;
    tick;
    chk("idle_wr_ready", wr_ready, 1'b1);
    chk("idle_CEN", CEN, 1'b1);

    // write then cycle-exact len-4 burst
    for (int i = 0; i < 4; i++) wr(11'(i), 128'hA0 + 128'(i));
    rd_start = 1'b1; rd_base = 11'h0; rd_len = 12'd4; out_ready = 1'b1;
    tick;                                   // E0
    rd_start = 1'b0;
    chk("e0_issue", {rd_busy, CEN, WEN, A}, {3'b101, 11'h0});
    tick;                                   // E1
    chk("e1_issue", {CEN, A, out_valid}, {1'b0, 11'h1, 1'b0});
    tick;                                   // E2
    chk("e2_out", {out_valid, out_last, out_data}, {2'b10, 128'hA0});
    chk("e2_A", {CEN, A}, {1'b0, 11'h2});
    tick;
    chk("e3_out", {out_valid, out_data}, {1'b1, 128'hA1});
    chk("e3_A", {CEN, A}, {1'b0, 11'h3});
    tick;
    chk("e4_out", {out_valid, out_data, CEN}, {1'b1, 128'hA2, 1'b1});
    tick;
    chk("e5_out", {out_valid, out_last, out_data}, {2'b11, 128'hA3});
    chk("e5_status", {done, rd_busy}, 2'b01);
    tick;
    chk("e6_done", {out_valid, done, rd_busy, wr_ready}, 4'b0101);
    tick;
    chk("e7_done_low", done, 1'b0);

    // address wrap plus an ignored rd_start mid-burst
    wr(11'h7FE, 128'hB0); wr(11'h7FF, 128'hB1); wr(11'h000, 128'hB2); wr(11'h001, 128'hB3);
    burst(11'h7FE, 12'd4, 2, "wrap");
    tick;
    chk("wrap_after", {rd_busy, done}, 2'b00);

    // backpressure
    for (int i = 0; i < 8; i++) wr(11'h40 + 11'(i), 128'hE0 + 128'(i));
    burst(11'h40, 12'd8, 1, "bp");
    tick;

    // zero-length read is ignored
    rd_start = 1'b1; rd_base = 11'h5; rd_len = 12'd0;
    #1;
    chk("len0_wr_ready", {wr_ready, CEN}, 2'b11);
    tick;
    rd_start = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (!CEN || rd_busy || done) ok = 1'b0;
      tick;
    end
    chk("len0_quiet", ok, 1'b1);

    // rd_start wins over a simultaneous write; the write lands after done
    wr_valid = 1'b1; wr_addr = 11'h10; wr_data = 128'hDD;
    burst(11'h0, 12'd4, 0, "prio");
    chk("prio_write", {CEN, WEN, A, D}, {2'b00, 11'h10, 128'hDD});
    tick;
    wr_valid = 1'b0;
    exp_mem[11'h10] = 128'hDD;
    burst(11'h10, 12'd1, 0, "prio_rb");
    tick;

    // reset on the 3rd output word of a len-6 burst
    for (int i = 0; i < 6; i++) wr(11'h20 + 11'(i), 128'hC0 + 128'(i));
    rd_start = 1'b1; rd_base = 11'h20; rd_len = 12'd6; out_ready = 1'b1;
    tick;
    rd_start = 1'b0;
    got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (out_valid && got == 2) break;
      if (out_valid) got++;
      tick;
    end
    chk("rst_mid_word3", {out_valid, out_data}, {1'b1, 128'hC2});
    reset = 1'b1;
    #1;
    chk("rst_mid_CEN", {CEN, wr_ready}, 2'b10);
    tick;
    chk("rst_mid_after", {out_valid, rd_busy, done}, 3'b000);
    reset = 1'b0;
    tick;
    chk("rst_mid_no_done", {out_valid, rd_busy, done}, 3'b000);
    burst(11'h0, 12'd2, 0, "post_rst");
    tick;

    // full sweep, exact and clamped length
    for (int i = 0; i < 2048; i++) wr(11'(i), 128'(i));
    burst(11'h0, 12'd2048, 0, "sweep2048");
    tick;
    burst(11'h0, 12'd4095, 0, "sweep4095");
    tick;
    chk("final_idle", {rd_busy, done, out_valid}, 3'b000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
